burst_enable_gen: RTL and testbench
===================================

# burst_enable_gen

Programmable enable-strobe generator that drives the `enable` input of a downstream `counter` instance. On a `start` request it issues a burst of single-cycle enable pulses, one every `prescale`+1 clocks, for `burst_len` pulses or continuously. It reports progress (`busy`, `done`, `pulse_cnt`) and can optionally terminate a burst on the counter's `rollover` output.

## Interface
- `PRESCALE_WIDTH`, default 8: width of the prescale field and internal divider.
- `BURST_WIDTH`, default 8: width of `burst_len` and `pulse_cnt`.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  burst request; sampled only in IDLE.
- `abort`  in  1  cancels a running burst.
- `prescale`  in  `PRESCALE_WIDTH`  pulse period minus 1; latched on accepted `start`.
- `burst_len`  in  `BURST_WIDTH`  pulses per burst; 0 = continuous; latched on accepted `start`.
- `rollover_in`  in  1  downstream counter `rollover`; present only with the macro in Configuration.
- `enable`  out  1  strobe to the downstream counter `enable`.
- `busy`  out  1  high while in RUN.
- `done`  out  1  single-cycle pulse at burst completion.
- `pulse_cnt`  out  `BURST_WIDTH`  pulses issued in the current or last burst.

## Operation
- FSM states are IDLE, RUN and DONE.
- **IDLE**
  - `start`=1 and `abort`=0: latch `prescale`/`burst_len`, load divider with `prescale`, clear `pulse_cnt`, go to RUN.
  - `start` and `abort` both high: stay in IDLE.
- **RUN**
  - `enable` = (divider == 0), decoded from registers with no input path.
  - On each edge with divider ≠ 0: divider decrements.
  - On each edge with divider == 0: reload the divider with the latched prescale and increment `pulse_cnt`, wrapping mod 2^`BURST_WIDTH`.
  - If latched `burst_len` ≠ 0 and the incremented `pulse_cnt` equals `burst_len`, go to DONE.
- **DONE**: `done`=1 for exactly one cycle, then IDLE. `start` is ignored in DONE.
- **`abort` in RUN**: go to IDLE at the next edge. No `done` pulse. `pulse_cnt` holds. An `enable` already high in that cycle still counts.
- **`start` while busy**: ignored. Input changes to `prescale`/`burst_len` during RUN have no effect.
- **`prescale` = 0**: `enable` is high every RUN cycle, i.e. continuously high for `burst_len` cycles.
- **`burst_len` = 0**: RUN until `abort` (or rollover stop). `pulse_cnt` wraps freely.
- **Reset values**: state IDLE, `enable` 0, `busy` 0, `done` 0, `pulse_cnt` 0, divider 0.
- **Reset mid-burst**: immediate return to reset values. No `done`.

## Timing
- `start` sampled at edge k: `busy` rises after edge k.
- First `enable` is high in the cycle following edge k+`prescale`; the counter consumes it at edge k+`prescale`+1.
- Subsequent pulses are spaced `prescale`+1 cycles apart.
- Last pulse consumed at edge m: `busy` falls and `done` rises after edge m; `done` falls after edge m+1.
- Earliest next accepted `start`: edge m+2.
- `enable`, `busy` and `done` are never high together with `done` from the same burst; `enable` is 0 whenever `busy` is 0.

## Configuration
- `BURST_ENABLE_GEN_ROLLOVER_STOP_EN`
  - **Defined**: port `rollover_in` exists. `rollover_in`=1 sampled in RUN ends the burst exactly like reaching `burst_len`: go to DONE and pulse `done`. A pulse in the same cycle is counted. `abort` in the same cycle wins (IDLE, no `done`).
  - **Undefined**: port absent; termination only by `burst_len` or `abort`.

## Structure
- Package `burst_enable_gen_pkg`:
  - state enum typedef `burst_state_t` {IDLE, RUN, DONE};
  - default width constants `PRESCALE_WIDTH_DEF` and `BURST_WIDTH_DEF`.
- Sub-module `presc_div`: loadable down-counter with a zero flag and reload. The FSM and the pulse counter stay in the top module.

## Test plan
- **Basic burst**: Reset, `prescale`=2, `burst_len`=4, `start` at edge k.
  - `enable` is high in the cycles after edges k+2, k+5, k+8 and k+11.
  - `done` is high after edge k+12.
  - `pulse_cnt`=4.
- **Chained counter**: Drive a `counter` (WIDTH 4, MAX 15) with `prescale`=0, `burst_len`=20.
  - Counter value goes 0..15 then 0..3.
  - `done` is high after 20 enable cycles.
- **Abort**: `prescale`=3, `burst_len`=0, `abort` asserted after the 5th pulse.
  - Returns to IDLE with no `done`.
  - `pulse_cnt`=5 and `enable` stays 0.
- **Start filtering**:
  - `start`+`abort` together in IDLE → stays IDLE.
  - `start` during RUN and during DONE → ignored.
  - Latched `prescale` is unaffected by an input change mid-burst.
- **Reset mid-burst**: `reset_n` low between pulses.
  - All outputs are 0 asynchronously.
  - A new `start` after release behaves as in scenario 1.
- **Rollover stop** (macro defined): counter MAX 15, `prescale`=0, `burst_len`=0.
  - Burst ends on the first `rollover`.
  - `done` pulses and `pulse_cnt`=16.

Source files
------------

// File: rtl/burst_enable_gen_pkg.sv
// rtl/burst_enable_gen_pkg.sv - shared types and default widths for burst_enable_gen
//
// Contents:
//   PRESCALE_WIDTH_DEF - default width of the prescale field and divider
//   BURST_WIDTH_DEF    - default width of burst_len and pulse_cnt
//   burst_state_t      - burst FSM state encoding (IDLE, RUN, DONE)

package burst_enable_gen_pkg;

    localparam int PRESCALE_WIDTH_DEF = 8;
    localparam int BURST_WIDTH_DEF    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } burst_state_t;

endpackage : burst_enable_gen_pkg

// File: rtl/burst_enable_gen_presc_div.sv
// rtl/burst_enable_gen_presc_div.sv - loadable prescale down-counter with zero flag and reload
//
// Module presc_div
// Parameters:
//   WIDTH        - divider width
// Ports:
//   clk          in   clock, rising edge
//   reset_n      in   asynchronous active-low reset, divider clears to 0
//   load         in   load load_value (takes priority over run)
//   load_value   in   value loaded on load
//   run          in   count: decrement, or reload from reload_value when at zero
//   reload_value in   value reloaded when the divider expires while running
//   zero         out  divider currently equals zero (register decode only)

module presc_div #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             run,
    input  logic [WIDTH-1:0] reload_value,
    output logic             zero
);

    logic [WIDTH-1:0] div_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= '0;
        end else if (load) begin
            div_q <= load_value;
        end else if (run) begin
            if (div_q == '0) begin
                div_q <= reload_value;
            end else begin
                div_q <= div_q - {{(WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    assign zero = (div_q == '0);

endmodule : presc_div

// File: rtl/burst_enable_gen.sv
// rtl/burst_enable_gen.sv - programmable enable-strobe burst generator for a downstream counter
//
// Optional feature macro: BURST_ENABLE_GEN_ROLLOVER_STOP_EN
//   When defined, the rollover_in port exists and a sampled rollover in RUN
//   ends the burst through DONE, just like reaching burst_len.
//
// Parameters:
//   PRESCALE_WIDTH - width of prescale and the internal divider
//   BURST_WIDTH    - width of burst_len and pulse_cnt
// Ports:
//   clk          in   clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   start        in   burst request, sampled only in IDLE
//   abort        in   cancels a running burst (no done)
//   prescale     in   pulse period minus one, latched on accepted start
//   burst_len    in   pulses per burst, 0 = continuous, latched on accepted start
//   rollover_in  in   downstream counter rollover (macro builds only)
//   enable       out  single-cycle strobe to the downstream counter
//   busy         out  high while in RUN
//   done         out  one-cycle pulse at burst completion
//   pulse_cnt    out  pulses issued in the current or last burst

module burst_enable_gen
    import burst_enable_gen_pkg::*;
#(
    parameter int PRESCALE_WIDTH = PRESCALE_WIDTH_DEF,
    parameter int BURST_WIDTH    = BURST_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic [BURST_WIDTH-1:0]    burst_len,
`ifdef BURST_ENABLE_GEN_ROLLOVER_STOP_EN
    input  logic                      rollover_in,
`endif
    output logic                      enable,
    output logic                      busy,
    output logic                      done,
    output logic [BURST_WIDTH-1:0]    pulse_cnt
);

    burst_state_t state_q;
    burst_state_t state_d;

    logic [PRESCALE_WIDTH-1:0] prescale_q;
    logic [BURST_WIDTH-1:0]    burst_len_q;
    logic [BURST_WIDTH-1:0]    pulse_cnt_q;
    logic [BURST_WIDTH-1:0]    cnt_inc;

    logic accept;
    logic in_run;
    logic div_zero;
    logic last_pulse;
    logic stop_req;

    // A start is accepted only in IDLE and only when abort is not asserted
    // in the same cycle.
    assign accept  = (state_q == IDLE) && start && !abort;
    assign in_run  = (state_q == RUN);
    assign cnt_inc = pulse_cnt_q + {{(BURST_WIDTH-1){1'b0}}, 1'b1};

    presc_div #(
        .WIDTH (PRESCALE_WIDTH)
    ) u_presc_div (
        .clk          (clk),
        .reset_n      (reset_n),
        .load         (accept),
        .load_value   (prescale),
        .run          (in_run),
        .reload_value (prescale_q),
        .zero         (div_zero)
    );

    // The strobe is a pure decode of registered state so the downstream
    // counter never sees a combinational path from our inputs.
    assign enable = in_run && div_zero;

    // Finite burst completes on the pulse that brings the count up to the
    // latched length; a zero length never matches and runs until stopped.
    assign last_pulse = enable && (burst_len_q != '0) && (cnt_inc == burst_len_q);

`ifdef BURST_ENABLE_GEN_ROLLOVER_STOP_EN
    assign stop_req = last_pulse || rollover_in;
`else
    assign stop_req = last_pulse;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                // abort outranks every completion condition in the same cycle
                if (abort) begin
                    state_d = IDLE;
                end else if (stop_req) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescale_q  <= '0;
            burst_len_q <= '0;
        end else if (accept) begin
            prescale_q  <= prescale;
            burst_len_q <= burst_len;
        end
    end

    // An enable that is high in the abort cycle has already been seen by the
    // downstream counter, so it is still counted here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pulse_cnt_q <= '0;
        end else if (accept) begin
            pulse_cnt_q <= '0;
        end else if (enable) begin
            pulse_cnt_q <= cnt_inc;
        end
    end

    assign pulse_cnt = pulse_cnt_q;

endmodule : burst_enable_gen

// File: tb/tb_burst_enable_gen.sv
// tb/tb_burst_enable_gen.sv - self-checking bench for burst_enable_gen

module tb_burst_enable_gen;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       abort;
    logic [7:0] prescale;
    logic [7:0] burst_len;
    logic       enable;
    logic       busy;
    logic       done;
    logic [7:0] pulse_cnt;

    // downstream counter model, WIDTH 4, MAX 15
    logic       ctr_clr;
    logic [3:0] ctr_val;
    logic       rollover;

    int n_checks;
    int n_fail;

    typedef struct {
        logic       start;
        logic       abort;
        logic [7:0] prescale;
        logic [7:0] burst_len;
        logic       exp_enable;
        logic       exp_busy;
        logic       exp_done;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs[16];

    burst_enable_gen dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .abort       (abort),
        .prescale    (prescale),
        .burst_len   (burst_len),
`ifdef BURST_ENABLE_GEN_ROLLOVER_STOP_EN
        .rollover_in (rollover),
`endif
        .enable      (enable),
        .busy        (busy),
        .done        (done),
        .pulse_cnt   (pulse_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rollover = enable && (ctr_val == 4'hF);

    always @(posedge clk) begin
        if (ctr_clr) begin
            ctr_val <= 4'h0;
        end else if (enable) begin
            ctr_val <= (ctr_val == 4'hF) ? 4'h0 : ctr_val + 4'h1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            start     = vecs[i].start;
            abort     = vecs[i].abort;
            prescale  = vecs[i].prescale;
            burst_len = vecs[i].burst_len;
            step();
            chk($sformatf("vec%0d enable", i), int'(enable), int'(vecs[i].exp_enable));
            chk($sformatf("vec%0d busy", i), int'(busy), int'(vecs[i].exp_busy));
            chk($sformatf("vec%0d done", i), int'(done), int'(vecs[i].exp_done));
            chk($sformatf("vec%0d pulse_cnt", i), int'(pulse_cnt), int'(vecs[i].exp_cnt));
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // basic burst prescale 2 len 4, with start filtering folded in
        //             start abort pre   len    en    busy  done  cnt
        vecs[0]  = '{1'b1, 1'b0, 8'd2, 8'd4, 1'b0, 1'b1, 1'b0, 8'd0};
        vecs[1]  = '{1'b0, 1'b0, 8'd2, 8'd4, 1'b0, 1'b1, 1'b0, 8'd0};
        vecs[2]  = '{1'b0, 1'b0, 8'd2, 8'd4, 1'b1, 1'b1, 1'b0, 8'd0};
        vecs[3]  = '{1'b0, 1'b0, 8'd2, 8'd4, 1'b0, 1'b1, 1'b0, 8'd1};
        vecs[4]  = '{1'b0, 1'b0, 8'd2, 8'd4, 1'b0, 1'b1, 1'b0, 8'd1};
        vecs[5]  = '{1'b1, 1'b0, 8'd7, 8'd1, 1'b1, 1'b1, 1'b0, 8'd1};
        vecs[6]  = '{1'b0, 1'b0, 8'd7, 8'd1, 1'b0, 1'b1, 1'b0, 8'd2};
        vecs[7]  = '{1'b0, 1'b0, 8'd7, 8'd1, 1'b0, 1'b1, 1'b0, 8'd2};
        vecs[8]  = '{1'b0, 1'b0, 8'd7, 8'd1, 1'b1, 1'b1, 1'b0, 8'd2};
        vecs[9]  = '{1'b0, 1'b0, 8'd7, 8'd1, 1'b0, 1'b1, 1'b0, 8'd3};
        vecs[10] = '{1'b0, 1'b0, 8'd7, 8'd1, 1'b0, 1'b1, 1'b0, 8'd3};
        vecs[11] = '{1'b0, 1'b0, 8'd7, 8'd1, 1'b1, 1'b1, 1'b0, 8'd3};
        vecs[12] = '{1'b0, 1'b0, 8'd7, 8'd1, 1'b0, 1'b0, 1'b1, 8'd4};
        vecs[13] = '{1'b1, 1'b0, 8'd7, 8'd1, 1'b0, 1'b0, 1'b0, 8'd4};
        vecs[14] = '{1'b1, 1'b1, 8'd5, 8'd2, 1'b0, 1'b0, 1'b0, 8'd4};
        vecs[15] = '{1'b0, 1'b0, 8'd5, 8'd2, 1'b0, 1'b0, 1'b0, 8'd4};

        reset_n   = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        prescale  = 8'd0;
        burst_len = 8'd0;
        ctr_clr   = 1'b1;
        #12;
        chk("reset enable", int'(enable), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset pulse_cnt", int'(pulse_cnt), 0);
        #10;
        reset_n = 1'b1;
        step();

        run_vecs(0, 15);

        // chained counter: prescale 0, burst_len 20
        ctr_clr = 1'b1;
        step();
        ctr_clr   = 1'b0;
        prescale  = 8'd0;
        burst_len = 8'd20;
        start     = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("chain enable %0d", i), int'(enable), 1);
            chk($sformatf("chain counter %0d", i), int'(ctr_val), i % 16);
            step();
        end
        chk("chain done", int'(done), 1);
        chk("chain busy", int'(busy), 0);
        chk("chain enable end", int'(enable), 0);
        chk("chain pulse_cnt", int'(pulse_cnt), 20);
        chk("chain counter end", int'(ctr_val), 4);
        step();
        chk("chain done falls", int'(done), 0);

        // abort in the cycle of the 5th pulse: that pulse still counts
        prescale  = 8'd3;
        burst_len = 8'd0;
        start     = 1'b1;
        step();
        start = 1'b0;
        begin
            bit found;
            found = 1'b0;
            for (int c = 0; c < 40 && !found; c++) begin
                if (enable && pulse_cnt == 8'd4) found = 1'b1;
                else step();
            end
            chk("abort 5th pulse reached", int'(found), 1);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort busy", int'(busy), 0);
        chk("abort done", int'(done), 0);
        chk("abort pulse_cnt", int'(pulse_cnt), 5);
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("abort enable idle %0d", c), int'(enable), 0);
            chk($sformatf("abort done idle %0d", c), int'(done), 0);
            step();
        end
        chk("abort pulse_cnt holds", int'(pulse_cnt), 5);

        // reset mid-burst, between pulses
        prescale  = 8'd2;
        burst_len = 8'd4;
        start     = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        chk("pre-reset pulse_cnt", int'(pulse_cnt), 1);
        chk("pre-reset busy", int'(busy), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async reset enable", int'(enable), 0);
        chk("async reset busy", int'(busy), 0);
        chk("async reset done", int'(done), 0);
        chk("async reset pulse_cnt", int'(pulse_cnt), 0);
        #3;
        reset_n = 1'b1;
        step();
        chk("post-reset idle done", int'(done), 0);
        run_vecs(0, 13);

`ifdef BURST_ENABLE_GEN_ROLLOVER_STOP_EN
        ctr_clr = 1'b1;
        step();
        ctr_clr   = 1'b0;
        prescale  = 8'd0;
        burst_len = 8'd0;
        start     = 1'b1;
        step();
        start = 1'b0;
        begin
            bit seen;
            seen = 1'b0;
            for (int c = 0; c < 40 && !seen; c++) begin
                if (done) seen = 1'b1;
                else step();
            end
            chk("rollover done seen", int'(seen), 1);
        end
        chk("rollover pulse_cnt", int'(pulse_cnt), 16);
        chk("rollover counter", int'(ctr_val), 0);
        chk("rollover busy", int'(busy), 0);
        step();
        chk("rollover done falls", int'(done), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_burst_enable_gen
